comma_align_lock: RTL and testbench
===================================

Name: comma_align_lock

Overview:
- Parametrised successor to the receive-side comma detector; sits between the deserialiser and the 8b/10b decoder.
- Searches every bit offset of the incoming word stream for either comma polarity and selects the alignment offset.
- Runs an acquire/lock/loss state machine and outputs word-aligned symbols, an aligned comma flag and a lock indication.
- Replaces the fixed-offset, single-pattern detector; adds offset search, lock hysteresis and realignment.

Parameters:
- W, 10, symbol width in bits.
- COMMA_P, 10'b00_1111_1010, comma pattern, positive disparity (W bits).
- COMMA_N, 10'b11_0000_0101, comma pattern, negative disparity (W bits).
- LOCK_CNT, 3, consecutive same-offset commas needed to declare lock (1..15).
- UNLOCK_CNT, 4, consecutive other-offset commas in LOCKED that force loss of lock (1..15).

Ports:
- clk  in  1  word clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  W  raw deserialised word; bit 0 is the earliest received bit.
- data_in_valid  in  1  data_in is a new word this cycle.
- data_out  out  W  aligned symbol.
- data_out_valid  out  1  data_out is valid; only asserted while locked.
- comma_out  out  1  data_out is a comma (either polarity).
- locked  out  1  alignment lock.
- align_off  out  $clog2(W)  current alignment offset.
- realign  out  1  one-cycle pulse when align_off changes.

Behaviour:
- Reset: all outputs 0, FSM = UNLOCKED, prev_word = 0, all counters = 0.
- Window: win[2W-1:0] = {data_in, prev_word}.
  - prev_word <= data_in on each data_in_valid.
  - Candidate k (0..W-1) = win[k+W-1:k].
  - match[k] = candidate equals COMMA_P or COMMA_N.
  - Lowest k wins when several match. hit_any = |match. hit_cur = match[align_off].
- When data_in_valid = 0: FSM, counters, prev_word and align_off hold; data_out_valid = 0 and comma_out = 0 next cycle; realign = 0.
- Datapath latency: 1 clk. On a valid cycle, the next edge registers:
  - data_out <= win[align_off_next +: W], where align_off_next is the offset after this cycle's FSM update.
  - comma_out <= match[align_off_next].
  - data_out_valid <= (next state == LOCKED).
- FSM, evaluated only on valid cycles:
  - UNLOCKED, on hit_any: align_off <= lowest matching k; acq_cnt <= 1; go to ACQUIRE, or straight to LOCKED if LOCK_CNT == 1.
  - ACQUIRE:
    - hit_cur: acq_cnt++; when acq_cnt reaches LOCK_CNT, go to LOCKED and clear mis_cnt.
    - hit_any without hit_cur: restart with the new offset, acq_cnt <= 1.
    - No hit: hold.
  - LOCKED:
    - hit_cur: mis_cnt <= 0.
    - hit_any without hit_cur: mis_cnt++; when mis_cnt reaches UNLOCK_CNT, go to UNLOCKED with acq_cnt = mis_cnt = 0 and align_off held.
    - No hit: hold.
- locked = (state == LOCKED), registered.
- realign pulses for 1 clk whenever align_off is written with a different value. Rewriting the same value gives no pulse.
- Counters saturate and never wrap; widths are sized to hold their parameter.
- Reset asserted mid-stream takes effect immediately (asynchronous). Acquisition restarts from UNLOCKED after release.

Test Plan:
- Reset then idle: rst=1 for 3 clk, data_in_valid=0 -> all outputs 0, align_off=0, no realign pulse.
- Acquire at offset 3: stream with 0011111010 starting at bit 3, every 4th word, LOCK_CNT=3 -> realign pulse on first comma, align_off=3, locked rises 1 clk after the 3rd comma, data_out=0011111010 with comma_out=1 on comma words, data_out_valid=1 thereafter.
- Restart in ACQUIRE: 2 commas at offset 3, then a comma at offset 7 -> align_off=7, acq_cnt=1, locked stays 0 until 2 further commas at offset 7 (3 total).
- Loss of lock: locked at offset 3, then 4 consecutive commas at offset 5, UNLOCK_CNT=4 -> locked=0 and data_out_valid=0 after the 4th; a good offset-3 comma after the 3rd bad one resets mis_cnt so lock holds.
- Gaps and polarity: alternate 1100000101/0011111010 with data_in_valid low every other cycle -> same lock timing counted in valid words only; outputs frozen/invalid on gap cycles.
- Reset mid-lock: assert rst between edges while locked -> locked=0 immediately; after release, full re-acquisition is required.

Source files
------------

// File: rtl/comma_align_lock.sv
// Receive-side comma aligner: searches all bit offsets for either comma polarity,
// acquires/locks/loses alignment with hysteresis and emits word-aligned symbols.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | no alignment; first comma seen at any offset starts acquire
// ACQUIRE  | counting consecutive commas at align_off toward LOCK_CNT
// LOCKED   | aligned; commas at other offsets counted toward UNLOCK_CNT
module comma_align_lock #(
    parameter int            W          = 10,
    parameter logic [W-1:0]  COMMA_P    = 10'b00_1111_1010,
    parameter logic [W-1:0]  COMMA_N    = 10'b11_0000_0101,
    parameter int            LOCK_CNT   = 3,
    parameter int            UNLOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          data_in,
    input  logic                  data_in_valid,
    output logic [W-1:0]          data_out,
    output logic                  data_out_valid,
    output logic                  comma_out,
    output logic                  locked,
    output logic [$clog2(W)-1:0]  align_off,
    output logic                  realign
);

    localparam int OW = $clog2(W);
    localparam int AW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    prev_word;
    logic [2*W-1:0]  win;
    logic [W-1:0]    match;
    logic            hit_any, hit_cur;
    logic [OW-1:0]   first_k, off_nx;
    logic [AW-1:0]   acq_cnt, acq_nx, acq_inc;
    logic [MW-1:0]   mis_cnt, mis_nx, mis_inc;
    logic [W-1:0]    dsel;
    logic            csel;

    assign win = {data_in, prev_word};

    // Match every offset; the downward scan leaves the lowest matching k.
    always_comb begin
        match   = '0;
        first_k = '0;
        hit_cur = 1'b0;
        for (int k = 0; k < W; k++) begin
            match[k] = (win[k +: W] == COMMA_P) || (win[k +: W] == COMMA_N);
        end
        for (int k = W - 1; k >= 0; k--) begin
            if (match[k]) first_k = OW'(k);
        end
        for (int k = 0; k < W; k++) begin
            if (match[k] && (OW'(k) == align_off)) hit_cur = 1'b1;
        end
    end

    assign hit_any = |match;
    assign acq_inc = (acq_cnt == '1) ? acq_cnt : acq_cnt + 1'b1;
    assign mis_inc = (mis_cnt == '1) ? mis_cnt : mis_cnt + 1'b1;

    always_comb begin
        state_nx = state;
        off_nx   = align_off;
        acq_nx   = acq_cnt;
        mis_nx   = mis_cnt;
        if (data_in_valid) begin
            unique case (state)
                UNLOCKED: begin
                    if (hit_any) begin
                        off_nx = first_k;
                        acq_nx = AW'(1);
                        if (LOCK_CNT == 1) begin
                            state_nx = LOCKED;
                            mis_nx   = '0;
                        end else begin
                            state_nx = ACQUIRE;
                        end
                    end
                end
                ACQUIRE: begin
                    if (hit_cur) begin
                        acq_nx = acq_inc;
                        if (acq_inc >= AW'(LOCK_CNT)) begin
                            state_nx = LOCKED;
                            mis_nx   = '0;
                        end
                    end else if (hit_any) begin
                        off_nx = first_k;
                        acq_nx = AW'(1);
                    end
                end
                LOCKED: begin
                    if (hit_cur) begin
                        mis_nx = '0;
                    end else if (hit_any) begin
                        mis_nx = mis_inc;
                        if (mis_inc >= MW'(UNLOCK_CNT)) begin
                            state_nx = UNLOCKED;
                            acq_nx   = '0;
                            mis_nx   = '0;
                        end
                    end
                end
                default: state_nx = UNLOCKED;
            endcase
        end
    end

    // Output symbol follows the offset chosen on this same word.
    always_comb begin
        dsel = '0;
        csel = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (OW'(k) == off_nx) begin
                dsel = win[k +: W];
                csel = match[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= UNLOCKED;
            prev_word      <= '0;
            align_off      <= '0;
            acq_cnt        <= '0;
            mis_cnt        <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            comma_out      <= 1'b0;
            realign        <= 1'b0;
        end else if (data_in_valid) begin
            state          <= state_nx;
            prev_word      <= data_in;
            align_off      <= off_nx;
            acq_cnt        <= acq_nx;
            mis_cnt        <= mis_nx;
            data_out       <= dsel;
            data_out_valid <= (state_nx == LOCKED);
            comma_out      <= csel;
            realign        <= (off_nx != align_off);
        end else begin
            data_out_valid <= 1'b0;
            comma_out      <= 1'b0;
            realign        <= 1'b0;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_comma_align_lock.sv
// Directed bench for comma_align_lock: acquire, restart, loss of lock,
// gapped mixed-polarity input and asynchronous reset while locked.
module tb_comma_align_lock;

    localparam logic [9:0] CP = 10'b00_1111_1010;
    localparam logic [9:0] CN = 10'b11_0000_0101;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] data_in;
    logic       data_in_valid;
    logic [9:0] data_out;
    logic       data_out_valid;
    logic       comma_out;
    logic       locked;
    logic [3:0] align_off;
    logic       realign;

    int n_assert = 0;
    int n_fail   = 0;

    comma_align_lock dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .comma_out      (comma_out),
        .locked         (locked),
        .align_off      (align_off),
        .realign        (realign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [9:0] w, input logic v);
        data_in       = w;
        data_in_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Place comma c at window offset k (k >= 1): low part in word A, high part in word B.
    task automatic comma(input int k, input logic [9:0] c, input bit gap);
        logic [9:0] a, b;
        a = c << k;
        b = c >> (10 - k);
        send(a, 1'b1);
        if (gap) send(10'h3FF, 1'b0);
        send(b, 1'b1);
    endtask

    task automatic pad2();
        send(10'h000, 1'b1);
        send(10'h000, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        data_in = '0;
        data_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout",   16'(data_out), 16'h0);
        chk("rst_dov",    16'(data_out_valid), 16'h0);
        chk("rst_comma",  16'(comma_out), 16'h0);
        chk("rst_locked", 16'(locked), 16'h0);
        chk("rst_off",    16'(align_off), 16'h0);
        chk("rst_realign",16'(realign), 16'h0);
        rst = 1'b0;
        send(10'h000, 1'b0);
        send(10'h000, 1'b0);
        chk("idle_locked", 16'(locked), 16'h0);
        chk("idle_realign",16'(realign), 16'h0);

        // acquire at offset 3
        comma(3, CP, 1'b0);
        chk("acq1_realign", 16'(realign), 16'h1);
        chk("acq1_off",     16'(align_off), 16'h3);
        chk("acq1_locked",  16'(locked), 16'h0);
        chk("acq1_comma",   16'(comma_out), 16'h1);
        chk("acq1_dout",    16'(data_out), 16'(CP));
        chk("acq1_dov",     16'(data_out_valid), 16'h0);
        send(10'h000, 1'b1);
        chk("acq1_pulse_end", 16'(realign), 16'h0);
        send(10'h000, 1'b1);
        comma(3, CP, 1'b0);
        chk("acq2_locked",  16'(locked), 16'h0);
        chk("acq2_realign", 16'(realign), 16'h0);
        pad2();
        comma(3, CP, 1'b0);
        chk("acq3_locked",  16'(locked), 16'h1);
        chk("acq3_dov",     16'(data_out_valid), 16'h1);
        chk("acq3_dout",    16'(data_out), 16'(CP));
        chk("acq3_comma",   16'(comma_out), 16'h1);
        send(10'h000, 1'b1);
        chk("lk_dov",   16'(data_out_valid), 16'h1);
        chk("lk_comma", 16'(comma_out), 16'h0);
        chk("lk_dout",  16'(data_out), 16'h0);
        send(10'h000, 1'b1);

        // three bad commas, one good, then four bad
        for (int i = 0; i < 3; i++) begin
            comma(5, CP, 1'b0);
            chk("bad_a_locked", 16'(locked), 16'h1);
            chk("bad_a_comma",  16'(comma_out), 16'h0);
            pad2();
        end
        comma(3, CP, 1'b0);
        chk("good_locked", 16'(locked), 16'h1);
        chk("good_comma",  16'(comma_out), 16'h1);
        pad2();
        for (int i = 0; i < 3; i++) begin
            comma(5, CN, 1'b0);
            chk("bad_b_locked", 16'(locked), 16'h1);
            pad2();
        end
        comma(5, CP, 1'b0);
        chk("loss_locked",  16'(locked), 16'h0);
        chk("loss_dov",     16'(data_out_valid), 16'h0);
        chk("loss_off",     16'(align_off), 16'h3);
        chk("loss_realign", 16'(realign), 16'h0);
        pad2();

        // restart inside ACQUIRE
        comma(3, CP, 1'b0);
        chk("rs1_realign", 16'(realign), 16'h0);
        chk("rs1_off",     16'(align_off), 16'h3);
        chk("rs1_locked",  16'(locked), 16'h0);
        pad2();
        comma(3, CP, 1'b0);
        chk("rs2_locked", 16'(locked), 16'h0);
        pad2();
        comma(7, CN, 1'b0);
        chk("rs3_off",     16'(align_off), 16'h7);
        chk("rs3_realign", 16'(realign), 16'h1);
        chk("rs3_locked",  16'(locked), 16'h0);
        chk("rs3_dout",    16'(data_out), 16'(CN));
        chk("rs3_comma",   16'(comma_out), 16'h1);
        pad2();
        comma(7, CN, 1'b0);
        chk("rs4_locked", 16'(locked), 16'h0);
        pad2();
        comma(7, CN, 1'b0);
        chk("rs5_locked", 16'(locked), 16'h1);
        chk("rs5_dout",   16'(data_out), 16'(CN));
        send(10'h000, 1'b1);

        // asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        chk("arst_locked", 16'(locked), 16'h0);
        chk("arst_dov",    16'(data_out_valid), 16'h0);
        chk("arst_off",    16'(align_off), 16'h0);
        chk("arst_dout",   16'(data_out), 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // gapped input, alternating polarity
        comma(3, CN, 1'b1);
        chk("gap1_off",     16'(align_off), 16'h3);
        chk("gap1_realign", 16'(realign), 16'h1);
        chk("gap1_comma",   16'(comma_out), 16'h1);
        chk("gap1_dout",    16'(data_out), 16'(CN));
        chk("gap1_locked",  16'(locked), 16'h0);
        send(10'h3FF, 1'b0);
        chk("gap_idle_realign", 16'(realign), 16'h0);
        chk("gap_idle_comma",   16'(comma_out), 16'h0);
        chk("gap_idle_dov",     16'(data_out_valid), 16'h0);
        chk("gap_idle_dout",    16'(data_out), 16'(CN));
        send(10'h000, 1'b1);
        send(10'h3FF, 1'b0);
        comma(3, CP, 1'b1);
        chk("gap2_locked", 16'(locked), 16'h0);
        send(10'h000, 1'b1);
        send(10'h3FF, 1'b0);
        comma(3, CN, 1'b1);
        chk("gap3_locked", 16'(locked), 16'h1);
        chk("gap3_dov",    16'(data_out_valid), 16'h1);
        chk("gap3_comma",  16'(comma_out), 16'h1);
        chk("gap3_dout",   16'(data_out), 16'(CN));
        send(10'h3FF, 1'b0);
        chk("gap3_idle_dov",    16'(data_out_valid), 16'h0);
        chk("gap3_idle_locked", 16'(locked), 16'h1);
        chk("gap3_idle_comma",  16'(comma_out), 16'h0);
        chk("gap3_idle_dout",   16'(data_out), 16'(CN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
